// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: program loader and run sequencer for a processor core and its
// instruction memory.
//
// The core is held in reset while a host streams a program in over a byte-wide
// valid/ready port. The stream is LEN_LO, LEN_HI, then 2*LEN bytes, with each word
// sent low byte first. The words are written to instruction memory and the core
// is then released. It runs until it raises halt. The core is then parked with
// its state preserved, and the number of enabled cycles is reported.
//
// Parameters:
//   ADDR_W     instruction memory address width; capacity is 2^ADDR_W words
//   CNT_W      run-cycle counter width
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   start      begin a load (honoured only when idle or halted)
//   in_data    host byte
//   in_valid   host byte valid
//   in_ready   controller ready (a transfer occurs on in_valid & in_ready)
//   mem_we     one-cycle write strobe per word
//   mem_waddr  write address
//   mem_wdata  write data
//   cpu_rst    processor reset
//   cpu_en     processor clock enable
//   halt       processor halt flag
//   busy       controller is neither idle nor halted
//   done       the run ended on halt
//   err        the load was rejected because the length exceeds memory capacity
//   cycles     enabled cycles since the last start (saturating)
//
// Optional build macro PCTL_STEP_EN adds the step_mode and step inputs. While in
// RUN with step_mode=1, each cycle with step=1 enables the core for exactly one
// following cycle.
module prog_load_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic              halt,
`ifdef PCTL_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cycles
);

  localparam int unsigned MemWords = 1 << ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StDataLo,
    StDataHi,
    StArm,
    StRun,
    StHalt
  } state_e;

  state_e              state_q;
  logic [15:0]         len_q;
  logic [7:0]          lo_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                xfer;
  logic                run_en;
  logic [15:0]         len_full;

  assign xfer     = in_valid & in_ready;
  assign busy     = (state_q != StIdle) && (state_q != StHalt);
  // Full length as it becomes known on the LEN_HI transfer.
  assign len_full = {in_data, len_q[7:0]};

  // Value cpu_en takes for the next RUN cycle.
`ifdef PCTL_STEP_EN
  assign run_en = ~step_mode | step;
`else
  assign run_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      lo_q      <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      cpu_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cycles    <= '0;
    end else begin
      mem_we <= 1'b0;
      // Count every edge on which the core was enabled. The halting edge is included.
      if (cpu_en && (cycles != '1)) begin
        cycles <= cycles + CNT_W'(1);
      end

      case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            state_q  <= StLenLo;
            in_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cycles   <= '0;
            cpu_rst  <= 1'b1;
            cpu_en   <= 1'b0;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q[7:0] <= in_data;
            state_q    <= StLenHi;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_q[15:8] <= in_data;
            if (len_full == 16'd0) begin
              state_q  <= StArm;
              in_ready <= 1'b0;
            end else if (32'(len_full) > MemWords) begin
              err      <= 1'b1;
              state_q  <= StIdle;
              in_ready <= 1'b0;
            end else begin
              idx_q   <= '0;
              state_q <= StDataLo;
            end
          end
        end
        StDataLo: begin
          if (xfer) begin
            lo_q    <= in_data;
            state_q <= StDataHi;
          end
        end
        StDataHi: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_waddr <= idx_q;
            mem_wdata <= {in_data, lo_q};
            idx_q     <= idx_q + ADDR_W'(1);
            // The last write lands in the ARM cycle, while the core is still in reset.
            if (32'(idx_q) == 32'(len_q) - 32'd1) begin
              state_q  <= StArm;
              in_ready <= 1'b0;
            end else begin
              state_q <= StDataLo;
            end
          end
        end
        StArm: begin
          // halt is not looked at here. The core has not run yet.
          state_q <= StRun;
          cpu_rst <= 1'b0;
          cpu_en  <= run_en;
        end
        StRun: begin
          if (halt) begin
            // Stop the clock but keep the core out of reset so its state can be inspected.
            cpu_en  <= 1'b0;
            done    <= 1'b1;
            state_q <= StHalt;
          end else begin
            cpu_en <= run_en;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl, using the default build without step mode.
// Expected memory writes are queued as stimulus is issued. A monitor pops a queued
// write and compares it against the DUT each time mem_we pulses. The counter is
// narrowed to 5 bits so that saturation can be reached.
module tb_prog_load_ctrl;

  localparam int unsigned AddrW = 10;
  localparam int unsigned CntW  = 5;
  localparam int unsigned Words = 1 << AddrW;
  localparam int unsigned Sat   = (1 << CntW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [AddrW-1:0]  mem_waddr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst;
  logic              cpu_en;
  logic              halt;
  logic              busy;
  logic              done;
  logic              err;
  logic [CntW-1:0]   cycles;

  prog_load_ctrl #(
    .ADDR_W (AddrW),
    .CNT_W  (CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .cpu_en    (cpu_en),
    .halt      (halt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AddrW-1:0] addr;
    logic [15:0]      data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] prog[$];
  logic [15:0] mem_model[Words];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned k);
    return (k > Sat) ? Sat : k;
  endfunction

  // Write monitor and scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(mem_waddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_waddr), 32'(e.addr));
          check("write_data", 32'(mem_wdata), 32'(e.data));
        end
        check("write_core_held", 32'(cpu_rst), 32'd1);
        mem_model[mem_waddr] = mem_wdata;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cycles"}, 32'(cycles), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called and returns at a negedge. When gappy is set, one cycle of junk with
  // in_valid low precedes the byte.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n;
    if (gappy) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Loads prog[0..len-1]. Returns at the negedge of the ARM cycle, or of the IDLE
  // cycle when the length is rejected.
  task automatic do_load(input logic [15:0] len, input bit gappy, input bit hold_start);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    check("ld_in_ready", 32'(in_ready), 32'd1);
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_done_clr", 32'(done), 32'd0);
    check("ld_err_clr", 32'(err), 32'd0);
    check("ld_cycles_clr", 32'(cycles), 32'd0);
    check("ld_cpu_rst", 32'(cpu_rst), 32'd1);
    check("ld_cpu_en", 32'(cpu_en), 32'd0);
    send_byte(len[7:0], gappy);
    send_byte(len[15:8], gappy);
    if (32'(len) > Words) begin
      start = 1'b0;
      check("err_flag", 32'(err), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      check("err_in_ready", 32'(in_ready), 32'd0);
      check("err_cpu_rst", 32'(cpu_rst), 32'd1);
      repeat (3) @(negedge clk);
      check("err_no_writes", 32'(exp_q.size()), 32'd0);
      check("err_stays_idle", 32'(busy), 32'd0);
      check("err_cpu_rst_held", 32'(cpu_rst), 32'd1);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back('{addr: AddrW'(i), data: prog[i]});
      send_byte(prog[i][7:0], gappy);
      send_byte(prog[i][15:8], gappy);
    end
    start = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_in_ready", 32'(in_ready), 32'd0);
    check("arm_cpu_rst", 32'(cpu_rst), 32'd1);
    check("arm_cpu_en", 32'(cpu_en), 32'd0);
    check("arm_last_we", 32'(mem_we), (len != 16'd0) ? 32'd1 : 32'd0);
  endtask

  // Called at the ARM negedge. Raises halt once the bench's own count of RUN
  // cycles reaches n. The count saturates at the counter's maximum value.
  task automatic run_halt(input int unsigned n, input bit arm_halt);
    int unsigned k;
    halt = arm_halt;
    @(negedge clk);
    halt = 1'b0;
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_cpu_en", 32'(cpu_en), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    check("run_no_pending_writes", 32'(exp_q.size()), 32'd0);
    k = 0;
    forever begin
      check("run_cycles", 32'(cycles), sat(k));
      if (k == n) begin
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        break;
      end
      @(negedge clk);
      k++;
    end
    check("halt_cycles", 32'(cycles), sat(n + 1));
    check("halt_cpu_en", 32'(cpu_en), 32'd0);
    check("halt_cpu_rst", 32'(cpu_rst), 32'd0);
    check("halt_done", 32'(done), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("halt_cycles_frozen", 32'(cycles), sat(n + 1));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    halt     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // Stream 02 00 6F 00 00 6F, then run 6 cycles.
    prog = {16'h006F, 16'h6F00};
    do_load(16'd2, 1'b0, 1'b0);
    run_halt(5, 1'b0);
    check("mem0", 32'(mem_model[0]), 32'h006F);
    check("mem1", 32'(mem_model[1]), 32'h6F00);

    // Same stream with gaps and junk data. Also restarts from HALT.
    do_load(16'd2, 1'b1, 1'b0);
    run_halt(2, 1'b0);

    // A zero-length program goes straight to ARM. Start is held through ARM, and
    // halt is raised during ARM; both are ignored.
    do_load(16'd0, 1'b0, 1'b1);
    run_halt(3, 1'b1);

    // Rejected length 0x0401, then the exact capacity boundary 0x0400.
    do_load(16'h0401, 1'b0, 1'b0);
    prog.delete();
    for (int i = 0; i < int'(Words); i++) prog.push_back(16'($urandom));
    do_load(16'h0400, 1'b0, 1'b0);
    run_halt(1, 1'b0);
    check("mem_last", 32'(mem_model[Words-1]), 32'(prog[Words-1]));

    // Random programs, some long enough to saturate the counter.
    for (int it = 0; it < 6; it++) begin
      int unsigned len;
      len = $urandom_range(1, 8);
      prog.delete();
      for (int i = 0; i < int'(len); i++) prog.push_back(16'($urandom));
      do_load(16'(len), 1'($urandom), 1'($urandom));
      run_halt($urandom_range(0, 40), 1'b0);
    end

    // Reset in DATA_LO after one word has been written.
    prog = {16'hBEEF, 16'h1234, 16'h5555};
    send_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back('{addr: AddrW'(0), data: 16'hBEEF});
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    check("midrst_no_more_writes", 32'(exp_q.size()), 32'd0);
    check("midrst_mem0", 32'(mem_model[0]), 32'hBEEF);
    prog = {16'hC0DE};
    do_load(16'd1, 1'b0, 1'b0);
    run_halt(4, 1'b0);
    check("reload_mem0", 32'(mem_model[0]), 32'hC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
